// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Data has priority, fetch is protected from starvation, and a watchdog aborts unacknowledged accesses.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic        busy
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [WAIT_W-1:0]   WAIT_ONE   = WAIT_W'(1);
  localparam logic                WDOG_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t                state_r, state_s;
  owner_t                owner_r, owner_s;
  logic [STARVE_W-1:0]   starve_cnt_r, starve_s;
  logic [WAIT_W-1:0]     wait_cnt_r, wait_s;
  logic                  mem_req_r, mem_req_s;
  logic                  mem_wr_r, mem_wr_s;
  logic [31:0]           mem_addr_r, mem_addr_s;
  logic [31:0]           mem_wdata_r, mem_wdata_s;
  logic                  i_ack_r, i_ack_s;
  logic                  d_ack_r, d_ack_s;
  logic [31:0]           i_rdata_r, i_rdata_s;
  logic [31:0]           d_rdata_r, d_rdata_s;
  logic                  bus_err_r, bus_err_s;
  logic                  busy_r, busy_s;
  logic                  grant_d_s;
  logic                  wdog_hit_s;
  logic [31:0]           resp_data_s;

  // Arbitration, transaction sequencing and next values for every registered output.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    starve_s    = starve_cnt_r;
    wait_s      = wait_cnt_r;
    mem_req_s   = mem_req_r;
    mem_wr_s    = mem_wr_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    i_ack_s     = 1'b0;
    d_ack_s     = 1'b0;
    i_rdata_s   = i_rdata_r;
    d_rdata_s   = d_rdata_r;
    bus_err_s   = 1'b0;
    resp_data_s = 32'h0000_0000;
    grant_d_s   = d_req && (!i_req || (starve_cnt_r < STARVE_LIM));
    wdog_hit_s  = WDOG_EN && (wait_cnt_r == WAIT_LAST);

    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_s     = ST_WAIT;
          owner_s     = OWN_DATA;
          mem_req_s   = 1'b1;
          mem_wr_s    = d_wr;
          mem_addr_s  = d_addr;
          mem_wdata_s = d_wdata;
          wait_s      = {WAIT_W{1'b0}};
          // Only data grants that overtake a waiting fetch count toward starvation.
          if (i_req) begin
            if (starve_cnt_r != STARVE_LIM) begin
              starve_s = starve_cnt_r + STARVE_ONE;
            end else begin
              starve_s = starve_cnt_r;
            end
          end else begin
            starve_s = {STARVE_W{1'b0}};
          end
        end else if (i_req) begin
          state_s     = ST_WAIT;
          owner_s     = OWN_FETCH;
          mem_req_s   = 1'b1;
          mem_wr_s    = 1'b0;
          mem_addr_s  = i_addr;
          mem_wdata_s = 32'h0000_0000;
          wait_s      = {WAIT_W{1'b0}};
          starve_s    = {STARVE_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // A real ack wins over watchdog expiry in the same cycle.
        if (mem_ack || wdog_hit_s) begin
          state_s   = ST_RESP;
          mem_req_s = 1'b0;
          bus_err_s = !mem_ack;
          if (mem_ack && !mem_wr_r) begin
            resp_data_s = mem_rdata;
          end else begin
            resp_data_s = 32'h0000_0000;
          end
          if (owner_r == OWN_DATA) begin
            d_ack_s   = 1'b1;
            d_rdata_s = resp_data_s;
          end else begin
            i_ack_s   = 1'b1;
            i_rdata_s = resp_data_s;
          end
        end else begin
          wait_s = wait_cnt_r + WAIT_ONE;
        end
      end

      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State register and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_FETCH;
      starve_cnt_r <= {STARVE_W{1'b0}};
      wait_cnt_r   <= {WAIT_W{1'b0}};
      mem_req_r    <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      i_ack_r      <= 1'b0;
      d_ack_r      <= 1'b0;
      i_rdata_r    <= 32'h0000_0000;
      d_rdata_r    <= 32'h0000_0000;
      bus_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      starve_cnt_r <= starve_s;
      wait_cnt_r   <= wait_s;
      mem_req_r    <= mem_req_s;
      mem_wr_r     <= mem_wr_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      i_ack_r      <= i_ack_s;
      d_ack_r      <= d_ack_s;
      i_rdata_r    <= i_rdata_s;
      d_rdata_r    <= d_rdata_s;
      bus_err_r    <= bus_err_s;
      busy_r       <= busy_s;
    end
  end

  assign i_ack     = i_ack_r;
  assign i_rdata   = i_rdata_r;
  assign d_ack     = d_ack_r;
  assign d_rdata   = d_rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign bus_err   = bus_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model predicts the
// grant winner, memory handshake length, ack data and bus errors of every transaction.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .busy(busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_model [logic [31:0]];
  int          starve_m = 0;
  logic [31:0] last_i_rdata = 32'h0;
  logic [31:0] last_d_rdata = 32'h0;
  logic [7:0]  grant_bits   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    else return a ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h0000_2000 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  task automatic new_fetch(input logic [31:0] a);
    i_req  = 1'b1;
    i_addr = a;
  endtask

  task automatic new_data(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    d_req   = 1'b1;
    d_wr    = wr;
    d_addr  = a;
    d_wdata = wd;
  endtask

  // mode 0: caller set the requests; 1: both requesters kept busy; 2: random requests
  task automatic do_round(input int mode, input int lat_fix);
    logic        win_d;
    logic        w_wr;
    logic        timed_out;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] exp_data;
    int          lat;
    int          wlen;
    int          exp_len;
    int          r;

    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    chk("idle_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);

    if (mode == 1) begin
      if (!i_req) new_fetch(rand_addr());
      if (!d_req) new_data(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end else if (mode == 2) begin
      if (!i_req && $urandom_range(0, 2) != 0) new_fetch(rand_addr());
      if (!d_req && ($urandom_range(0, 2) != 0 || !i_req))
        new_data(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end

    // Data wins unless fetch waits and has already been overtaken STARVE_MAX times in a row.
    win_d = d_req && (!i_req || starve_m < STARVE_MAX);
    if (win_d && i_req) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
    else starve_m = 0;

    w_addr  = win_d ? d_addr : i_addr;
    w_wr    = win_d ? d_wr : 1'b0;
    w_wdata = d_wdata;

    if (lat_fix >= 0) lat = lat_fix;
    else begin
      r = int'($urandom_range(0, 11));
      if (r < 9) lat = int'($urandom_range(0, 3));
      else if (r == 9) lat = TIMEOUT - 1;
      else lat = TIMEOUT;
    end
    timed_out = (lat >= TIMEOUT);
    exp_len   = timed_out ? TIMEOUT : lat + 1;
    exp_data  = (timed_out || w_wr) ? 32'h0 : mem_rd(w_addr);

    step();
    mem_ack = 1'b0;
    wlen = 0;
    while (mem_req === 1'b1 && wlen < TIMEOUT + 4) begin
      chk("wait_addr", mem_addr, w_addr);
      chk("wait_wr", 32'(mem_wr), 32'(w_wr));
      if (w_wr) chk("wait_wdata", mem_wdata, w_wdata);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
      if (wlen == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_wr ? $urandom : mem_rd(mem_addr);
        if (mem_wr) mem_model[mem_addr] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      step();
      wlen++;
    end
    mem_ack = 1'b0;

    chk("mem_req_len", 32'(wlen), 32'(exp_len));
    chk("resp_i_ack", 32'(i_ack), 32'(!win_d));
    chk("resp_d_ack", 32'(d_ack), 32'(win_d));
    chk("resp_bus_err", 32'(bus_err), 32'(timed_out));
    if (win_d) last_d_rdata = exp_data;
    else last_i_rdata = exp_data;
    chk("resp_i_rdata", i_rdata, last_i_rdata);
    chk("resp_d_rdata", d_rdata, last_d_rdata);
    chk("resp_busy", 32'(busy), 32'd1);
    grant_bits = {grant_bits[6:0], win_d};

    if (win_d) d_req = 1'b0;
    else i_req = 1'b0;
    if (mode == 2) begin
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) step();
    chk("rst_outputs", 32'({i_ack, d_ack, mem_req, mem_wr, bus_err, busy}), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr | mem_wdata, 32'h0);
    rst = 1'b0;
    step();

    mem_model[32'h0000_0100] = 32'hA5A5_0001;
    new_fetch(32'h0000_0100);
    do_round(0, 0);
    new_data(1'b1, 32'h0000_2000, 32'h1234_5678);
    do_round(0, 3);
    new_data(1'b0, 32'h0000_3000, 32'h0);
    do_round(0, TIMEOUT);
    mem_model[32'h0000_3004] = 32'hCAFE_F00D;
    new_data(1'b0, 32'h0000_3004, 32'h0);
    do_round(0, TIMEOUT - 1);
    new_data(1'b0, 32'h0000_2000, 32'h0);
    do_round(0, 1);

    grant_bits = 8'h00;
    repeat (8) do_round(1, -1);
    chk("grant_order", 32'(grant_bits), 32'h0000_00EE);

    repeat (120) do_round(2, -1);

    for (int k = 0; k < 8 && starve_m != 2; k++) do_round(1, -1);
    if (!i_req) new_fetch(rand_addr());
    if (!d_req) new_data(1'b0, rand_addr(), 32'h0);
    step();
    chk("rst_pre_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_outputs", 32'({i_ack, d_ack, mem_req, bus_err, busy}), 32'd0);
    chk("rst_mid_rdata", i_rdata | d_rdata, 32'h0);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("late_ack_ignored", 32'({i_ack, d_ack, mem_req, bus_err, busy}), 32'd0);
    starve_m = 0; last_i_rdata = 32'h0; last_d_rdata = 32'h0;

    grant_bits = 8'h00;
    repeat (8) do_round(1, -1);
    chk("grant_order_after_rst", 32'(grant_bits), 32'h0000_00EE);
    repeat (20) do_round(2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch requester and its data (load/store) requester. It arbitrates with data priority plus a starvation guard for fetch, and sequences each transaction through a req/ack handshake with variable memory latency. A watchdog terminates transactions that the memory never acknowledges. It sits between the core's imem/dmem interfaces and the external memory.

Parameters:
STARVE_MAX, 3, maximum consecutive data grants while fetch is pending; the next grant then goes to fetch (must be >= 1).
TIMEOUT, 16, number of WAIT cycles without mem_ack before the transaction is aborted; 0 disables the watchdog.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
i_req  in  1  fetch request; held high with i_addr stable until i_ack
i_addr  in  32  fetch address
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  32  fetch data, valid while i_ack=1
d_req  in  1  data request; held high with d_wr/d_addr/d_wdata stable until d_ack
d_wr  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  32  load data, valid while d_ack=1 (0 for stores)
mem_req  out  1  memory request, held until mem_ack or timeout
mem_wr  out  1  memory write strobe, qualified by mem_req
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, sampled when mem_ack=1
mem_ack  in  1  memory completion, one-cycle pulse
bus_err  out  1  one-cycle pulse coincident with the ack of a timed-out transaction
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs are 0. starve_cnt=0, wait_cnt=0, owner cleared. Reset mid-transaction abandons the transaction: no ack is emitted and mem_req drops on the next edge.
- All outputs are registered.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE, no request: stay in IDLE.
- IDLE, arbitration:
  - If d_req=1 and (i_req=0 or starve_cnt<STARVE_MAX), grant data.
  - Otherwise, if i_req=1, grant fetch.
- IDLE, on grant (cycle N):
  - Latch owner, addr, wr and wdata; wr=0 for fetch.
  - Go to WAIT; mem_req/mem_wr/mem_addr/mem_wdata are driven from cycle N+1.
  - Clear wait_cnt.
- starve_cnt update at a grant:
  - Data granted while i_req=1: increment, saturating at STARVE_MAX.
  - Fetch granted, or data granted with i_req=0: clear.
- WAIT:
  - mem_req=1 with stable address and data.
  - If mem_ack=1 in cycle M: capture mem_rdata and go to RESP. In cycle M+1, mem_req=0 and owner_ack=1. owner_rdata = captured value for loads/fetches, 0 for stores.
  - Otherwise wait_cnt increments.
  - If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with mem_ack=0: go to RESP with err set. owner_ack=1, owner_rdata=0 and bus_err=1 in the next cycle.
  - mem_ack in the same cycle as timeout expiry counts as a normal completion, no error.
- RESP: lasts exactly one cycle, then IDLE. Requesters sample the ack in RESP. A req still high in the following IDLE cycle is a new request.
- Minimum transaction = 3 cycles (IDLE grant, WAIT with immediate ack, RESP). Back-to-back throughput is 1 transaction per 3 cycles at zero memory wait.
- mem_ack outside WAIT is ignored.
- Only the owner's ack/rdata toggle; the non-owner's ack stays 0 and its rdata holds its last value.
- wait_cnt width is clog2(TIMEOUT+1) with a minimum of 1; starve_cnt width is clog2(STARVE_MAX+1).
- A requester dropping req before ack is a protocol violation. The transaction completes anyway and the ack is still issued.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, mem_ack one cycle after mem_req rises with mem_rdata=0xA5A5_0001 -> mem_addr=0x100, mem_wr=0. i_ack pulses once with i_rdata=0xA5A5_0001, 3 cycles after grant. d_ack stays 0.
- Store: d_req=1, d_wr=1, d_addr=0x2000, d_wdata=0x1234_5678, memory acks after 4 cycles -> mem_wr=1 with stable addr/data for 4 cycles. d_ack pulses with d_rdata=0. busy=0 the cycle after.
- Contention/starvation: i_req and d_req held high continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I. No grant is ever lost.
- Timeout: d_req load, mem_ack never asserted, TIMEOUT=16 -> mem_req high for exactly 16 cycles. Then d_ack=1, bus_err=1, d_rdata=0 in the same cycle. The next request proceeds normally.
- Timeout race: mem_ack arrives in the 16th WAIT cycle with rdata=0xCAFE_F00D -> normal ack, bus_err=0, d_rdata=0xCAFE_F00D.
- Reset mid-WAIT: rst=1 for one cycle during an outstanding fetch -> next cycle mem_req=0, busy=0, no i_ack. A late mem_ack is ignored and starve_cnt=0.
